// File: rtl/ex_operand_stage.sv
// EX-stage operand register: forwards rs1/rs2 from MEM/WB, selects ALU operands, handles stall/flush.
// Forwarding is built only when EX_OPERAND_FWD_EN is defined; otherwise register-file data is used.
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic        a_sel,
  input  logic        b_sel,
  input  logic [3:0]  alu_op_in,
  input  logic        reg_we_in,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_we,
  input  logic        wb_we,
  input  logic [31:0] mem_data,
  input  logic [31:0] wb_data,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALUop,
  output logic [31:0] store_data,
  output logic [4:0]  rd_out,
  output logic        we_out,
  output logic        valid_out
);

  localparam logic [3:0] ALU_XXX = 4'hF;

  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;
  logic        w_load_dp;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_alu_op;
  logic [31:0] r_store_data;
  logic [4:0]  r_rd;
  logic        r_we;
  logic        r_valid;

`ifdef EX_OPERAND_FWD_EN
  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    w_fwd_rs1 = rs1_data;
    if (rs1_addr != 5'd0 && mem_we && mem_rd == rs1_addr) begin
      w_fwd_rs1 = mem_data;
    end else if (rs1_addr != 5'd0 && wb_we && wb_rd == rs1_addr) begin
      w_fwd_rs1 = wb_data;
    end
  end

  always_comb begin
    w_fwd_rs2 = rs2_data;
    if (rs2_addr != 5'd0 && mem_we && mem_rd == rs2_addr) begin
      w_fwd_rs2 = mem_data;
    end else if (rs2_addr != 5'd0 && wb_we && wb_rd == rs2_addr) begin
      w_fwd_rs2 = wb_data;
    end
  end
`else
  logic w_unused_fwd;

  assign w_fwd_rs1    = rs1_data;
  assign w_fwd_rs2    = rs2_data;
  assign w_unused_fwd = ^{rs1_addr, rs2_addr, mem_rd, wb_rd, mem_we, wb_we, mem_data, wb_data};
`endif

  // A flush still loads the datapath; only valid/we decide whether anything commits.
  assign w_load_dp = flush | ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_alu_op     <= ALU_XXX;
      r_store_data <= 32'd0;
      r_rd         <= 5'd0;
      r_we         <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      if (w_load_dp) begin
        r_a          <= a_sel ? pc : w_fwd_rs1;
        r_b          <= b_sel ? imm : w_fwd_rs2;
        r_alu_op     <= alu_op_in;
        r_store_data <= w_fwd_rs2;
        r_rd         <= rd_addr;
      end
      if (flush) begin
        r_valid <= 1'b0;
        r_we    <= 1'b0;
      end else if (!stall) begin
        r_valid <= valid_in;
        r_we    <= reg_we_in & valid_in & (rd_addr != 5'd0);
      end
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign ALUop      = r_alu_op;
  assign store_data = r_store_data;
  assign rd_out     = r_rd;
  assign we_out     = r_we;
  assign valid_out  = r_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized traffic vs. a model.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif
  localparam logic [3:0] AluXxx = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, stall, flush;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm, pc;
  logic        a_sel, b_sel;
  logic [3:0]  alu_op_in;
  logic        reg_we_in;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_we, wb_we;
  logic [31:0] mem_data, wb_data;
  logic [31:0] A, B, store_data;
  logic [3:0]  ALUop;
  logic [4:0]  rd_out;
  logic        we_out, valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state; m_known is cleared when the datapath content is unspecified.
  logic [31:0] m_a, m_b, m_sd;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_we, m_valid, m_known;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .imm(imm), .pc(pc), .a_sel(a_sel), .b_sel(b_sel),
    .alu_op_in(alu_op_in), .reg_we_in(reg_we_in), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_we(mem_we), .wb_we(wb_we), .mem_data(mem_data), .wb_data(wb_data),
    .A(A), .B(B), .ALUop(ALUop), .store_data(store_data), .rd_out(rd_out),
    .we_out(we_out), .valid_out(valid_out)
  );

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (FwdEn && a != 5'd0 && mem_we && mem_rd == a) return mem_data;
    if (FwdEn && a != 5'd0 && wb_we && wb_rd == a) return wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_sd = '0; m_op = AluXxx; m_rd = '0;
    m_we = 1'b0; m_valid = 1'b0; m_known = 1'b1;
  endtask

  // Advance the model with the inputs present now, then clock and settle.
  task automatic tick();
    if (flush) begin
      m_valid = 1'b0; m_we = 1'b0; m_known = 1'b0;
    end else if (!stall) begin
      m_valid = valid_in;
      m_we    = valid_in && reg_we_in && (rd_addr != 5'd0);
      m_a     = a_sel ? pc : ref_fwd(rs1_addr, rs1_data);
      m_b     = b_sel ? imm : ref_fwd(rs2_addr, rs2_data);
      m_sd    = ref_fwd(rs2_addr, rs2_data);
      m_op    = alu_op_in;
      m_rd    = rd_addr;
      m_known = valid_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; stall = 0; flush = 0; rs1_data = 0; rs2_data = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0; imm = 0; pc = 0; a_sel = 0; b_sel = 0;
    alu_op_in = 0; reg_we_in = 0; mem_rd = 0; wb_rd = 0; mem_we = 0; wb_we = 0;
    mem_data = 0; wb_data = 0;
  endtask

  task automatic rand_inputs(input bit allow_ctl);
    valid_in  = ($urandom_range(0, 4) != 0);
    stall     = allow_ctl && ($urandom_range(0, 3) == 0);
    flush     = allow_ctl && ($urandom_range(0, 7) == 0);
    rs1_data  = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
    rs1_addr  = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
    rd_addr   = 5'($urandom_range(0, 3));
    a_sel     = 1'($urandom); b_sel = 1'($urandom); alu_op_in = 4'($urandom);
    reg_we_in = 1'($urandom);
    mem_rd    = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
    mem_we    = 1'($urandom); wb_we = 1'($urandom);
    mem_data  = $urandom; wb_data = $urandom;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #3;
    n_tests++;
    if ({A, B, store_data, rd_out, we_out, valid_out} !== '0 || ALUop !== AluXxx) begin
      n_fail++;
      $display("FAIL reset_state A=%h B=%h sd=%h rd=%h we=%b v=%b op=%h exp zeros op=%h",
               A, B, store_data, rd_out, we_out, valid_out, ALUop, AluXxx);
    end
    valid_in = 1; reg_we_in = 1; rd_addr = 5'd4; pc = 32'h44; a_sel = 1;
    @(posedge clk); #1;
    n_tests++;
    if (valid_out !== 1'b0 || we_out !== 1'b0 || A !== 32'd0 || ALUop !== AluXxx) begin
      n_fail++;
      $display("FAIL reset_held_over_edge v=%b we=%b A=%h op=%h exp 0 0 0 %h",
               valid_out, we_out, A, ALUop, AluXxx);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    valid_in = 1; rs1_addr = 5'd5; rs1_data = 32'h0BAD_0001;
    mem_rd = 5'd5; mem_we = 1; mem_data = 32'hAAAA0000;
    wb_rd = 5'd5; wb_we = 1; wb_data = 32'h0000_1234;
    tick();
    n_tests++;
    if (A !== (FwdEn ? 32'hAAAA0000 : 32'h0BAD_0001)) begin
      n_fail++;
      $display("FAIL fwd_mem_over_wb A=%h exp %h", A, FwdEn ? 32'hAAAA0000 : 32'h0BAD_0001);
    end

    clear_inputs();
    valid_in = 1; rs2_addr = 5'd0; rs2_data = 32'd0;
    mem_rd = 5'd0; mem_we = 1; mem_data = 32'hFFFFFFFF;
    wb_rd = 5'd0; wb_we = 1; wb_data = 32'hFFFF0000;
    tick();
    n_tests++;
    if (B !== 32'd0 || store_data !== 32'd0) begin
      n_fail++;
      $display("FAIL fwd_x0_blocked B=%h sd=%h exp 0 0", B, store_data);
    end

    clear_inputs();
    valid_in = 1; b_sel = 1; imm = 32'h7FF; rs2_addr = 5'd7; rs2_data = 32'h99;
    wb_rd = 5'd7; wb_we = 1; wb_data = 32'h55; mem_rd = 5'd7; mem_we = 0;
    mem_data = 32'hDEAD;
    tick();
    n_tests++;
    if (B !== 32'h7FF || store_data !== (FwdEn ? 32'h55 : 32'h99)) begin
      n_fail++;
      $display("FAIL fwd_store_imm B=%h sd=%h exp 7ff %h", B, store_data,
               FwdEn ? 32'h55 : 32'h99);
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    clear_inputs();
    valid_in = 1; a_sel = 1; pc = 32'h100; b_sel = 1; imm = 32'h20; alu_op_in = 4'h3;
    reg_we_in = 1; rd_addr = 5'd9;
    tick();
    n_tests++;
    if (valid_out !== 1'b1 || A !== 32'h100 || we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_load v=%b A=%h we=%b exp 1 100 1", valid_out, A, we_out);
    end
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'b0);
      stall = 1;
      tick();
      n_tests++;
      if (A !== 32'h100 || B !== 32'h20 || ALUop !== 4'h3 || valid_out !== 1'b1 ||
          rd_out !== 5'd9 || we_out !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d A=%h B=%h op=%h v=%b rd=%0d we=%b exp 100 20 3 1 9 1",
                 i, A, B, ALUop, valid_out, rd_out, we_out);
      end
    end
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    valid_in = 1; reg_we_in = 1; rd_addr = 5'd3;
    tick();
    n_tests++;
    if (valid_out !== 1'b1 || we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre v=%b we=%b exp 1 1", valid_out, we_out);
    end
    stall = 1; flush = 1;
    tick();
    n_tests++;
    if (valid_out !== 1'b0 || we_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_stall v=%b we=%b exp 0 0", valid_out, we_out);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    valid_in = 1; a_sel = 1; pc = 32'hCAFE; b_sel = 1; imm = 32'h77; alu_op_in = 4'h2;
    reg_we_in = 1; rd_addr = 5'd12; rs2_data = 32'h1357; rs2_addr = 5'd1;
    tick();
    n_tests++;
    if (valid_out !== 1'b1 || A !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL areset_pre v=%b A=%h exp 1 cafe", valid_out, A);
    end
    stall = 1;
    #1 reset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({A, B, store_data, rd_out, we_out, valid_out} !== '0 || ALUop !== AluXxx) begin
      n_fail++;
      $display("FAIL areset_async A=%h B=%h sd=%h rd=%h we=%b v=%b op=%h exp zeros op=%h",
               A, B, store_data, rd_out, we_out, valid_out, ALUop, AluXxx);
    end
    #1 reset = 1'b0;
    tick();
    n_tests++;
    if (valid_out !== 1'b0 || A !== 32'd0 || ALUop !== AluXxx) begin
      n_fail++;
      $display("FAIL areset_then_stall v=%b A=%h op=%h exp 0 0 %h",
               valid_out, A, ALUop, AluXxx);
    end
    stall = 0;
    tick();
    n_tests++;
    if (valid_out !== 1'b1 || A !== 32'hCAFE || ALUop !== 4'h2 || we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_first_load v=%b A=%h op=%h we=%b exp 1 cafe 2 1",
               valid_out, A, ALUop, we_out);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      tick();
      n_tests++;
      if (valid_out !== m_valid) begin
        n_fail++;
        $display("FAIL rand_valid cyc %0d got %b exp %b", i, valid_out, m_valid);
      end
      n_tests++;
      if (we_out !== m_we) begin
        n_fail++;
        $display("FAIL rand_we cyc %0d got %b exp %b", i, we_out, m_we);
      end
      if (m_known) begin
        n_tests++;
        if (A !== m_a || B !== m_b || store_data !== m_sd || ALUop !== m_op ||
            rd_out !== m_rd) begin
          n_fail++;
          $display("FAIL rand_dp cyc %0d A=%h/%h B=%h/%h sd=%h/%h op=%h/%h rd=%0d/%0d",
                   i, A, m_a, B, m_b, store_data, m_sd, ALUop, m_op, rd_out, m_rd);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_stall();
    test_stall_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
